program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: receives a word count, N big-endian 16-bit words and an
// XOR checksum, writes the words to memory, then releases or blocks the processor.
module program_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_write,
    output logic              cpu_run,
    output logic              load_err,
    output logic [2:0]        load_state
);

    typedef enum logic [2:0] {
        CNT = 3'd0,
        HI  = 3'd1,
        LO  = 3'd2,
        WR  = 3'd3,
        CHK = 3'd4,
        RUN = 3'd5,
        ERR = 3'd6
    } state_t;

    state_t            state, state_next;
    logic [6:0]        word_total;
    logic [6:0]        words_done;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data_r;
    logic [7:0]        csum;
    logic              accept;

    assign accept     = in_valid && in_ready;
    assign mem_addr   = addr;
    assign mem_data   = data_r;
    assign load_state = state;

    // NOTE: every output of this block gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            CNT: begin
                in_ready = 1'b1;
                if (accept) state_next = HI;
            end
            HI: begin
                in_ready = 1'b1;
                if (accept) state_next = LO;
            end
            LO: begin
                in_ready = 1'b1;
                if (accept) state_next = WR;
            end
            WR: begin
                mem_write  = 1'b1;
                state_next = (words_done + 7'd1 < word_total) ? HI : CHK;
            end
            CHK: begin
                in_ready = 1'b1;
                if (accept) state_next = (in_data == csum) ? RUN : ERR;
            end
            RUN:     state_next = RUN;
            ERR:     state_next = ERR;
            default: state_next = CNT;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples the
    // pre-edge values and the order of statements inside the block does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CNT;
            word_total <= '0;
            words_done <= '0;
            addr       <= '0;
            data_r     <= '0;
            csum       <= '0;
            cpu_run    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state    <= state_next;
            cpu_run  <= (state_next == RUN);
            load_err <= (state_next == ERR);
            case (state)
                CNT: if (accept) begin
                    // A count of 0 (or 64) means a full 64-word image.
                    word_total <= {in_data[5:0] == 6'd0, in_data[5:0]};
                    words_done <= '0;
                    addr       <= '0;
                    csum       <= '0;
                end
                HI: if (accept) begin
                    data_r[15:8] <= in_data;
                    csum         <= csum ^ in_data;
                end
                LO: if (accept) begin
                    data_r[7:0] <= in_data;
                    csum        <= csum ^ in_data;
                end
                WR: begin
                    addr       <= addr + ADDR_W'(1);
                    words_done <= words_done + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
